// File: rtl/mips_core_pkg.sv
// Shared rename/retire types: register and tag widths plus the active-list entry.
package mips_core_pkg;

    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned PHYS_W        = $clog2(NUM_PHYS_REGS);
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned ARCH_W        = $clog2(NUM_ARCH_REGS);
    localparam int unsigned AL_DEPTH      = 32;
    localparam int unsigned TAG_W         = $clog2(AL_DEPTH);
    localparam int unsigned CNT_W         = TAG_W + 1;

    typedef logic [PHYS_W-1:0] PhysReg;
    typedef logic [ARCH_W-1:0] ArchReg;
    typedef logic [TAG_W-1:0]  AlTag;
    typedef logic [CNT_W-1:0]  AlCount;

    typedef struct packed {
        logic   valid;
        logic   done;
        logic   uses_rw;
        ArchReg arch;
        PhysReg new_phys;
        PhysReg old_phys;
    } ActiveListEntry;

    typedef enum logic {
        RUN  = 1'b0,
        WALK = 1'b1
    } AlState;

endpackage

// File: rtl/active_list_retire.sv
// Active list: in-order retire of renamed instructions and youngest-first
// squash walk after a mispredict, both feeding freed registers to the free list.
module active_list_retire
    import mips_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic              disp_uses_rw,
    input  logic [ARCH_W-1:0] disp_arch,
    input  logic [PHYS_W-1:0] disp_new_phys,
    input  logic [PHYS_W-1:0] disp_old_phys,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              cmp_valid,
    input  logic [TAG_W-1:0]  cmp_tag,
    input  logic              flush_valid,
    input  logic [TAG_W-1:0]  flush_tag,
    output logic              fl_w_en,
    output logic [PHYS_W-1:0] fl_dat,
    output logic              rt_valid,
    output logic [ARCH_W-1:0] rt_arch,
    output logic [PHYS_W-1:0] rt_phys,
    output logic              rb_valid,
    output logic [ARCH_W-1:0] rb_arch,
    output logic [PHYS_W-1:0] rb_phys,
    output logic              recovering
);

    ActiveListEntry al_q [AL_DEPTH];
    ActiveListEntry al_d [AL_DEPTH];
    AlState         state_q, state_d;
    AlTag           head_q, head_d;
    AlTag           tail_q, tail_d;
    AlTag           target_q, target_d;
    AlCount         count_q, count_d;

    logic           fl_w_en_q, fl_w_en_d;
    PhysReg         fl_dat_q, fl_dat_d;
    logic           rt_valid_q, rt_valid_d;
    ArchReg         rt_arch_q, rt_arch_d;
    PhysReg         rt_phys_q, rt_phys_d;
    logic           rb_valid_q, rb_valid_d;
    ArchReg         rb_arch_q, rb_arch_d;
    PhysReg         rb_phys_q, rb_phys_d;

    logic           disp_fire;
    logic           retire;
    AlTag           flush_target;
    AlTag           walk_idx;

    // Ready and tag come straight from state flops, never from inputs.
    assign disp_ready = (state_q == RUN) && (count_q != AlCount'(AL_DEPTH));
    assign disp_tag   = tail_q;
    assign recovering = (state_q == WALK);

    assign fl_w_en  = fl_w_en_q;
    assign fl_dat   = fl_dat_q;
    assign rt_valid = rt_valid_q;
    assign rt_arch  = rt_arch_q;
    assign rt_phys  = rt_phys_q;
    assign rb_valid = rb_valid_q;
    assign rb_arch  = rb_arch_q;
    assign rb_phys  = rb_phys_q;

    // Next-state: completion marking, dispatch, retire, flush decision and walk pops.
    always_comb begin
        al_d         = al_q;
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        target_d     = target_q;
        count_d      = count_q;
        fl_w_en_d    = 1'b0;
        fl_dat_d     = '0;
        rt_valid_d   = 1'b0;
        rt_arch_d    = '0;
        rt_phys_d    = '0;
        rb_valid_d   = 1'b0;
        rb_arch_d    = '0;
        rb_phys_d    = '0;
        disp_fire    = disp_valid && disp_ready && !flush_valid;
        retire       = 1'b0;
        flush_target = flush_tag + AlTag'(1);
        walk_idx     = tail_q - AlTag'(1);

        if (cmp_valid && al_q[cmp_tag].valid) begin
            al_d[cmp_tag].done = 1'b1;
        end

        unique case (state_q)
            RUN: begin
                if (disp_fire) begin
                    al_d[tail_q] = '{valid: 1'b1, done: 1'b0, uses_rw: disp_uses_rw,
                                     arch: disp_arch, new_phys: disp_new_phys,
                                     old_phys: disp_old_phys};
                    tail_d = tail_q + AlTag'(1);
                end
                if (al_q[head_q].valid && al_q[head_q].done) begin
                    retire             = 1'b1;
                    al_d[head_q].valid = 1'b0;
                    head_d             = head_q + AlTag'(1);
                    if (al_q[head_q].uses_rw) begin
                        fl_w_en_d  = 1'b1;
                        fl_dat_d   = al_q[head_q].old_phys;
                        rt_valid_d = 1'b1;
                        rt_arch_d  = al_q[head_q].arch;
                        rt_phys_d  = al_q[head_q].new_phys;
                    end
                end
                count_d = count_q + AlCount'(disp_fire) - AlCount'(retire);
                if (flush_valid && (tail_q != flush_target)) begin
                    state_d  = WALK;
                    target_d = flush_target;
                end
            end
            WALK: begin
                al_d[walk_idx].valid = 1'b0;
                tail_d               = walk_idx;
                count_d              = count_q - AlCount'(1);
                if (al_q[walk_idx].uses_rw) begin
                    rb_valid_d = 1'b1;
                    rb_arch_d  = al_q[walk_idx].arch;
                    rb_phys_d  = al_q[walk_idx].old_phys;
                    fl_w_en_d  = 1'b1;
                    fl_dat_d   = al_q[walk_idx].new_phys;
                end
                if (walk_idx == target_q) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // State, storage and output pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            target_q   <= '0;
            count_q    <= '0;
            fl_w_en_q  <= 1'b0;
            fl_dat_q   <= '0;
            rt_valid_q <= 1'b0;
            rt_arch_q  <= '0;
            rt_phys_q  <= '0;
            rb_valid_q <= 1'b0;
            rb_arch_q  <= '0;
            rb_phys_q  <= '0;
            for (int i = 0; i < int'(AL_DEPTH); i++) begin
                al_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            target_q   <= target_d;
            count_q    <= count_d;
            fl_w_en_q  <= fl_w_en_d;
            fl_dat_q   <= fl_dat_d;
            rt_valid_q <= rt_valid_d;
            rt_arch_q  <= rt_arch_d;
            rt_phys_q  <= rt_phys_d;
            rb_valid_q <= rb_valid_d;
            rb_arch_q  <= rb_arch_d;
            rb_phys_q  <= rb_phys_d;
            al_q       <= al_d;
        end
    end

endmodule

// File: tb/tb_active_list_retire.sv
// Bench for active_list_retire: directed scenarios plus random traffic,
// all checked against a program-order queue model of the active list.
module tb_active_list_retire;
    import mips_core_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_valid;
    logic              disp_ready;
    logic              disp_uses_rw;
    logic [ARCH_W-1:0] disp_arch;
    logic [PHYS_W-1:0] disp_new_phys;
    logic [PHYS_W-1:0] disp_old_phys;
    logic [TAG_W-1:0]  disp_tag;
    logic              cmp_valid;
    logic [TAG_W-1:0]  cmp_tag;
    logic              flush_valid;
    logic [TAG_W-1:0]  flush_tag;
    logic              fl_w_en;
    logic [PHYS_W-1:0] fl_dat;
    logic              rt_valid;
    logic [ARCH_W-1:0] rt_arch;
    logic [PHYS_W-1:0] rt_phys;
    logic              rb_valid;
    logic [ARCH_W-1:0] rb_arch;
    logic [PHYS_W-1:0] rb_phys;
    logic              recovering;

    always #5 clk = ~clk;

    active_list_retire dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uses_rw(disp_uses_rw),
        .disp_arch(disp_arch), .disp_new_phys(disp_new_phys), .disp_old_phys(disp_old_phys),
        .disp_tag(disp_tag), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .fl_w_en(fl_w_en), .fl_dat(fl_dat),
        .rt_valid(rt_valid), .rt_arch(rt_arch), .rt_phys(rt_phys),
        .rb_valid(rb_valid), .rb_arch(rb_arch), .rb_phys(rb_phys),
        .recovering(recovering)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: instructions in program order, oldest at index 0.
    typedef struct {
        int tag;
        bit uses_rw;
        int arch;
        int newp;
        int oldp;
        bit done;
    } ent_t;

    ent_t mq[$];
    int   m_tail;
    int   m_walk;
    bit   e_fl, e_rt, e_rb;
    int   e_fl_dat, e_rt_arch, e_rt_phys, e_rb_arch, e_rb_phys;

    function automatic void model_reset();
        mq.delete();
        m_tail = 0;
        m_walk = 0;
        e_fl = 0; e_rt = 0; e_rb = 0;
    endfunction

    function automatic bit model_ready();
        return (m_walk == 0) && (mq.size() != 32);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        ent_t e;
        bit   rdy = model_ready();
        bit   ret = (m_walk == 0) && (mq.size() > 0) && mq[0].done;
        int   fidx = -1;
        e_fl = 0; e_rt = 0; e_rb = 0;
        if (flush_valid) begin
            foreach (mq[i]) if (mq[i].tag == int'(flush_tag)) fidx = i;
        end
        if (cmp_valid) begin
            foreach (mq[i]) if (mq[i].tag == int'(cmp_tag)) mq[i].done = 1;
        end
        if (m_walk > 0) begin
            e = mq.pop_back();
            m_tail = (m_tail + 31) % 32;
            m_walk--;
            if (e.uses_rw) begin
                e_rb = 1; e_rb_arch = e.arch; e_rb_phys = e.oldp;
                e_fl = 1; e_fl_dat = e.newp;
            end
        end else begin
            if (flush_valid && fidx >= 0) m_walk = mq.size() - 1 - fidx;
            if (ret) begin
                e = mq.pop_front();
                if (e.uses_rw) begin
                    e_rt = 1; e_rt_arch = e.arch; e_rt_phys = e.newp;
                    e_fl = 1; e_fl_dat = e.oldp;
                end
            end
            if (disp_valid && rdy && !flush_valid) begin
                e = '{tag: m_tail, uses_rw: disp_uses_rw, arch: int'(disp_arch),
                      newp: int'(disp_new_phys), oldp: int'(disp_old_phys), done: 0};
                mq.push_back(e);
                m_tail = (m_tail + 1) % 32;
            end
        end
    endfunction

    task automatic idle();
        disp_valid = 0; disp_uses_rw = 0; disp_arch = '0; disp_new_phys = '0; disp_old_phys = '0;
        cmp_valid = 0; cmp_tag = '0; flush_valid = 0; flush_tag = '0;
    endtask

    task automatic set_disp(input bit u, input int a, input int n, input int o);
        disp_valid = 1; disp_uses_rw = u;
        disp_arch = ARCH_W'(a); disp_new_phys = PHYS_W'(n); disp_old_phys = PHYS_W'(o);
    endtask

    // One cycle: check pre-edge state outputs, clock, then check the pulses.
    task automatic step();
        check_eq("disp_ready", 32'(disp_ready), 32'(model_ready()));
        check_eq("disp_tag", 32'(disp_tag), 32'(m_tail));
        check_eq("recovering", 32'(recovering), 32'(m_walk > 0));
        model_edge();
        @(posedge clk); #1;
        check_eq("fl_w_en", 32'(fl_w_en), 32'(e_fl));
        if (e_fl) check_eq("fl_dat", 32'(fl_dat), 32'(e_fl_dat));
        check_eq("rt_valid", 32'(rt_valid), 32'(e_rt));
        if (e_rt) begin
            check_eq("rt_arch", 32'(rt_arch), 32'(e_rt_arch));
            check_eq("rt_phys", 32'(rt_phys), 32'(e_rt_phys));
        end
        check_eq("rb_valid", 32'(rb_valid), 32'(e_rb));
        if (e_rb) begin
            check_eq("rb_arch", 32'(rb_arch), 32'(e_rb_arch));
            check_eq("rb_phys", 32'(rb_phys), 32'(e_rb_phys));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_fl_w_en"}, 32'(fl_w_en), 0);
        check_eq({tag, "_fl_dat"}, 32'(fl_dat), 0);
        check_eq({tag, "_rt_valid"}, 32'(rt_valid), 0);
        check_eq({tag, "_rt_arch"}, 32'(rt_arch), 0);
        check_eq({tag, "_rt_phys"}, 32'(rt_phys), 0);
        check_eq({tag, "_rb_valid"}, 32'(rb_valid), 0);
        check_eq({tag, "_rb_arch"}, 32'(rb_arch), 0);
        check_eq({tag, "_rb_phys"}, 32'(rb_phys), 0);
        check_eq({tag, "_recovering"}, 32'(recovering), 0);
        check_eq({tag, "_disp_tag"}, 32'(disp_tag), 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all_zero("reset");
        rst_n = 1;
        model_reset();
    endtask

    int walk_arch [3] = '{5, 4, 3};
    int walk_fl   [3] = '{44, 43, 42};

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        do_reset();

        // Single instruction through its minimum lifetime.
        set_disp(1, 3, 40, 3); step();
        idle(); cmp_valid = 1; cmp_tag = 5'd0; step();
        idle(); step();
        check_eq("t1_fl_dat", 32'(fl_dat), 3);
        check_eq("t1_rt_arch", 32'(rt_arch), 3);
        check_eq("t1_rt_phys", 32'(rt_phys), 40);
        step();
        check_eq("t1_empty", 32'(mq.size()), 0);

        // Out-of-order completion, in-order retire.
        do_reset();
        for (int k = 0; k < 3; k++) begin set_disp(1, k + 1, 40 + k, k + 1); step(); end
        for (int k = 2; k >= 0; k--) begin idle(); cmp_valid = 1; cmp_tag = 5'(k); step(); end
        idle();
        for (int k = 0; k < 4; k++) step();

        // Full list, blocked 33rd dispatch, one retire frees one slot, tail wraps.
        do_reset();
        for (int k = 0; k < 32; k++) begin set_disp(1, k % 32, k + 1, k); step(); end
        set_disp(1, 7, 7, 7); step();
        check_eq("t3_full_ready", 32'(disp_ready), 0);
        disp_valid = 0; cmp_valid = 1; cmp_tag = 5'd0; step();
        idle(); disp_valid = 1; step();
        check_eq("t3_ready_back", 32'(disp_ready), 1);
        step();
        idle(); step();
        check_eq("t3_wrap_tag", 32'(disp_tag), 1);

        // Mispredict walk over three younger entries.
        do_reset();
        for (int k = 0; k < 5; k++) begin set_disp(1, k + 1, 40 + k, k + 1); step(); end
        idle(); flush_valid = 1; flush_tag = 5'd1; step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t4_rb_arch", 32'(rb_arch), 32'(walk_arch[k]));
            check_eq("t4_rb_phys", 32'(rb_phys), 32'(walk_arch[k]));
            check_eq("t4_fl_dat", 32'(fl_dat), 32'(walk_fl[k]));
        end
        check_eq("t4_tail", 32'(disp_tag), 2);
        step();

        // Entries without a destination retire or squash silently.
        do_reset();
        set_disp(0, 9, 9, 9); step();
        set_disp(1, 2, 50, 2); step();
        set_disp(0, 3, 51, 3); step();
        idle(); cmp_valid = 1; cmp_tag = 5'd0; step();
        idle(); flush_valid = 1; flush_tag = 5'd1; step();
        idle(); step(); step();
        check_eq("t5_tail", 32'(disp_tag), 2);

        // Reset in the second walk cycle abandons the walk.
        do_reset();
        for (int k = 0; k < 5; k++) begin set_disp(1, k + 1, 40 + k, k + 1); step(); end
        idle(); flush_valid = 1; flush_tag = 5'd0; step();
        idle(); step();
        rst_n = 0;
        @(posedge clk); #1;
        check_all_zero("t6");
        rst_n = 1;
        model_reset();
        step();
        check_eq("t6_ready", 32'(disp_ready), 1);

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            idle();
            if ($urandom_range(99) < 65) set_disp($urandom_range(99) < 80, int'($urandom_range(31)),
                                                   int'($urandom_range(63)), int'($urandom_range(63)));
            if ($urandom_range(99) < 45) begin
                cmp_valid = 1;
                if (mq.size() > 0 && $urandom_range(3) != 0)
                    cmp_tag = 5'(mq[$urandom_range(mq.size() - 1)].tag);
                else
                    cmp_tag = 5'($urandom_range(31));
            end
            if ($urandom_range(99) < 4) begin
                if (m_walk > 0) begin
                    flush_valid = 1; flush_tag = 5'($urandom_range(31));
                end else if (mq.size() > 0) begin
                    flush_valid = 1; flush_tag = 5'(mq[$urandom_range(mq.size() - 1)].tag);
                end
            end
            step();
        end
        idle();
        for (int k = 0; k < 40; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
